// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state type, blank and nine digit codes, and a helper giving
// the number of decimal digits needed to show every value of a given width.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam logic [3:0] BCD_BLANK = 4'hF;
   localparam logic [3:0] BCD_NINE  = 4'h9;

   // Decimal digits in 2**width-1: floor(width*log10(2))+1. 2**width is
   // never a power of ten, so it has the same digit count as 2**width-1.
   function automatic int bcd_digits_for(input int width);
      return (width * 30103) / 100000 + 1;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single BCD digit adjust cell for shift-and-add-3 conversion.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   d  in  4  current digit
//   q  out 4  d+3 when d>=5, else d (4-bit, carry discarded)
module bcd_add3 (
   input  logic [3:0] d,
   output logic [3:0] q
);

   assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter, one input bit per clock (shift-and-add-3).
// Latency: accept at edge N, out_valid high from edge N+BIN_W; one result per BIN_W+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready low from accept until that handshake.
//
// Ports:
//   clk        in   1         rising-edge clock
//   rst        in   1         synchronous active-high reset, discards any conversion
//   in_valid   in   1         in_bin valid
//   in_ready   out  1         ready for a new value (IDLE only)
//   in_bin     in   BIN_W     unsigned binary value
//   out_valid  out  1         out_bcd/out_ovf valid and stable
//   out_ready  in   1         consumer takes the result
//   out_bcd    out  4*DIGITS  packed BCD, ones digit in [3:0]; all nines on overflow
//   out_ovf    out  1         value did not fit in DIGITS digits
// Optional: define BCD_BLANK_LEADING_EN to show leading zero digits as 4'hF in DONE.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BIN_W-1:0]    in_bin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] out_bcd,
   output logic                out_ovf
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = 4 * DIGITS;

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic [BIN_W-1:0]   bin;
   logic [BCD_W-1:0]   digits;
   logic [BCD_W-1:0]   adj;
   logic               ovf;

   // Every digit is adjusted in parallel before the shift; no carry between cells.
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .d (digits[4*g +: 4]),
         .q (adj[4*g +: 4])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         count     <= '0;
         bin       <= '0;
         digits    <= '0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  bin      <= in_bin;
                  digits   <= '0;
                  ovf      <= 1'b0;
                  count    <= CNT_W'(BIN_W - 1);
                  in_ready <= 1'b0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               // {digits, bin} shifts left by one; the MSB of the adjusted
               // top digit falls off the end and marks the value as too wide.
               digits <= {adj[BCD_W-2:0], bin[BIN_W-1]};
               bin    <= bin << 1;
               if (adj[BCD_W-1]) begin
                  ovf <= 1'b1;
               end
               if (count == '0) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  count <= count - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign out_ovf = ovf;

   // Output mux: saturation on overflow, optional leading-digit blanking.
   // Internal digits are never modified here.
`ifdef BCD_BLANK_LEADING_EN
   logic seen;
`endif
   always_comb begin
      out_bcd = ovf ? {DIGITS{BCD_NINE}} : digits;
`ifdef BCD_BLANK_LEADING_EN
      seen = 1'b0;
      if (state == DONE && !ovf) begin
         // Walk from the top digit down; blank until the first non-zero one.
         for (int i = DIGITS - 1; i >= 1; i--) begin
            if (digits[4*i +: 4] != 4'd0) begin
               seen = 1'b1;
            end
            if (!seen) begin
               out_bcd[4*i +: 4] = BCD_BLANK;
            end
         end
      end
`endif
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: three instances (8b/3d, 8b/2d, 14b/5d)
// driven with directed and random values, compared with a decimal reference model.
module tb_bin_to_bcd_seq;

   logic        clk;
   logic        rst;

   logic        v8, ordy8;
   logic [7:0]  bin8;
   logic        ir_a, ov_a, ovf_a;
   logic [11:0] bcd_a;
   logic        ir_b, ov_b, ovf_b;
   logic [7:0]  bcd_b;

   logic        v14, ordy14;
   logic [13:0] bin14;
   logic        ir_c, ov_c, ovf_c;
   logic [19:0] bcd_c;

   int errors = 0;
   int checks = 0;

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir_a), .in_bin(bin8),
      .out_valid(ov_a), .out_ready(ordy8), .out_bcd(bcd_a), .out_ovf(ovf_a));

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir_b), .in_bin(bin8),
      .out_valid(ov_b), .out_ready(ordy8), .out_bcd(bcd_b), .out_ovf(ovf_b));

   bin_to_bcd_seq #(.BIN_W(14), .DIGITS(5)) dut_c (
      .clk(clk), .rst(rst), .in_valid(v14), .in_ready(ir_c), .in_bin(bin14),
      .out_valid(ov_c), .out_ready(ordy14), .out_bcd(bcd_c), .out_ovf(ovf_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain decimal arithmetic.
   function automatic logic ref_ovf(input int val, input int nd);
      int lim = 1;
      for (int i = 0; i < nd; i++) lim = lim * 10;
      return (val >= lim);
   endfunction

   function automatic logic [31:0] ref_bcd(input int val, input int nd);
      logic [31:0] r = '0;
      int p = 1;
      int msd = 0;
      if (ref_ovf(val, nd)) begin
         for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'h9;
         return r;
      end
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'((val / p) % 10);
         if (((val / p) % 10) != 0) msd = i;
         p = p * 10;
      end
`ifdef BCD_BLANK_LEADING_EN
      for (int i = 1; i < nd; i++) if (i > msd) r[4*i +: 4] = 4'hF;
`endif
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run8(input int val, input int hold);
      int n;
      logic [11:0] ea;
      logic [7:0]  eb;
      logic [31:0] t;
      t  = ref_bcd(val, 3);
      ea = t[11:0];
      t  = ref_bcd(val, 2);
      eb = t[7:0];
      @(negedge clk);
      bin8 = 8'(val); v8 = 1'b1; ordy8 = 1'b0;
      n = 0;
      while (!ir_a && n < 50) begin @(negedge clk); n++; end
      check("accept8", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      v8 = 1'b0;
      if (hold == 0) ordy8 = 1'b1;   // out_ready during SHIFT must be ignored
      n = 0;
      while (!ov_a && n < 100) begin @(posedge clk); #1; n++; end
      check("lat8", n, 8);
      check("valid8_d2", ov_b, 1);
      check("bcd8_d3", bcd_a, ea);
      check("ovf8_d3", ovf_a, ref_ovf(val, 3));
      check("bcd8_d2", bcd_b, eb);
      check("ovf8_d2", ovf_b, ref_ovf(val, 2));
      check("inrdy_done", ir_a, 0);
      if (hold > 0) begin
         v8 = 1'b1; bin8 = 8'($urandom);   // must not be consumed while DONE
         for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", ov_a, 1);
            check("hold_bcd", bcd_a, ea);
            check("hold_inrdy", ir_a, 0);
         end
         ordy8 = 1'b1;
      end
      @(posedge clk); #1;
      v8 = 1'b0; ordy8 = 1'b0;
      check("valid_drop", ov_a, 0);
      check("inrdy_back", ir_a, 1);
      check("valid_drop_d2", ov_b, 0);
   endtask

   task automatic run14(input int val);
      int n;
      logic [31:0] t;
      t = ref_bcd(val, 5);
      @(negedge clk);
      bin14 = 14'(val); v14 = 1'b1; ordy14 = 1'b1;
      n = 0;
      while (!ir_c && n < 50) begin @(negedge clk); n++; end
      check("accept14", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      v14 = 1'b0;
      n = 0;
      while (!ov_c && n < 100) begin @(posedge clk); #1; n++; end
      check("lat14", n, 14);
      check("bcd14", bcd_c, t[19:0]);
      check("ovf14", ovf_c, ref_ovf(val, 5));
      @(posedge clk); #1;
      check("valid_drop14", ov_c, 0);
      ordy14 = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; v8 = 1'b0; ordy8 = 1'b0; bin8 = '0;
      v14 = 1'b0; ordy14 = 1'b0; bin14 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_inrdy", ir_a, 1);
      check("rst_valid", ov_a, 0);
      check("rst_bcd", bcd_a, 0);
      check("rst_ovf", ovf_a, 0);
      check("rst_valid14", ov_c, 0);
      @(negedge clk);
      rst = 1'b0;

      run8(255, 2);
      check("d255", bcd_a, 12'h255);
      run8(200, 0);
      run8(99, 5);
      run8(0, 1);
      run8(7, 0);
      run8(105, 1);

      // Reset on the third SHIFT cycle discards the conversion.
      @(negedge clk);
      bin8 = 8'd200; v8 = 1'b1;
      n = 0;
      while (!ir_a && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      v8 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_valid", ov_a, 0);
      check("midrst_inrdy", ir_a, 1);
      check("midrst_ovf_d2", ovf_b, 0);
      @(negedge clk);
      rst = 1'b0;
      run8(42, 0);
`ifndef BCD_BLANK_LEADING_EN
      check("d42", bcd_a, 12'h042);
`endif

      for (int i = 0; i < 20; i++) run8(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

      run14(9999);
      run14(0);
      run14(16383);
      for (int i = 0; i < 5; i++) run14(int'($urandom_range(0, 16383)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
